// File: rtl/seq_repetition_checker_pkg.sv
// Shared types and helpers for the repetition checker.
// Modes, channel FSM states and a counter-width helper.
package seq_rep_pkg;

  typedef enum logic [1:0] {
    REP_NONCONSEC,
    REP_GOTO,
    REP_CONSEC
  } rep_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    WAIT_DONE
  } rep_state_e;

  // Bits needed to hold 0..max_val.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_repetition_checker_if.sv
// Bundle between the observed DUT signals and the checker.
// master: drives en/trig/ev/done; slave: drives status and counters.
interface seq_repetition_checker_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic              en;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] pass;
  logic [NUM_CH-1:0] fail;
  logic [NUM_CH-1:0] fail_to;
  logic [NUM_CH-1:0] dropped;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;

  modport master (
    output en, trig, ev, done,
    input  busy, pass, fail, fail_to, dropped,
    input  pass_cnt, fail_cnt
  );

  modport slave (
    input  en, trig, ev, done,
    output busy, pass, fail, fail_to, dropped,
    output pass_cnt, fail_cnt
  );
endinterface

// File: rtl/seq_repetition_checker_channel.sv
// One checker thread: trig |-> ev{rep} ##1 done.
// In: clk, rst, en, trig, ev, done. Out: busy, pass, fail, fail_to, dropped.
module seq_rep_channel
  import seq_rep_pkg::*;
#(
  parameter int        REP_CNT = 3,
  parameter rep_mode_e MODE    = REP_NONCONSEC,
  parameter int        TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic trig,
  input  logic ev,
  input  logic done,
  output logic busy,
  output logic pass,
  output logic fail,
  output logic fail_to,
  output logic dropped
);

  localparam int KW = cnt_bits(REP_CNT);
  localparam int EW = cnt_bits(TIMEOUT);
  localparam logic [KW-1:0] K_MAX = KW'(REP_CNT);
  localparam logic [EW-1:0] E_MAX = EW'(TIMEOUT);

  rep_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [EW-1:0] elapsed_q, elapsed_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          fail_to_q, fail_to_d;
  logic          dropped_q, dropped_d;

  logic [KW-1:0] k_inc;
  logic [EW-1:0] el_inc;
  logic          hit;
  logic          miss;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    elapsed_d = elapsed_q;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    fail_to_d = 1'b0;
    dropped_d = trig && (state_q != IDLE);
    k_inc     = k_q + 1'b1;
    el_inc    = elapsed_q + 1'b1;
    hit       = 1'b0;
    miss      = 1'b0;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (trig) begin
            // ev in the trigger cycle already counts
            k_d       = KW'(ev);
            elapsed_d = '0;
            state_d   = (ev && REP_CNT == 1) ?
                        WAIT_DONE : COUNT;
          end
        end
        COUNT: begin
          if (ev) begin
            k_d = k_inc;
            if (k_inc == K_MAX) state_d = WAIT_DONE;
          end else if (MODE == REP_CONSEC) begin
            miss = 1'b1;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            hit = 1'b1;
          end else if (MODE != REP_NONCONSEC || ev) begin
            // goto/consec decide in one cycle;
            // nonconsec fails only on an extra ev
            miss = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
        elapsed_d = el_inc;
        if (hit || miss) begin
          pass_d  = hit;
          fail_d  = miss;
          state_d = IDLE;
        end else if (el_inc == E_MAX) begin
          fail_d    = 1'b1;
          fail_to_d = 1'b1;
          state_d   = IDLE;
        end
        if (state_d == IDLE) begin
          k_d       = '0;
          elapsed_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      elapsed_q <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      fail_to_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      elapsed_q <= elapsed_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      fail_to_q <= fail_to_d;
      dropped_q <= dropped_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign fail_to = fail_to_q;
  assign dropped = dropped_q;

endmodule

// File: rtl/seq_repetition_checker.sv
// Multi-channel repetition checker with saturating pass/fail totals.
// Ports: clk, rst, bus (slave: en/trig/ev/done in; status, counters out).
module seq_repetition_checker
  import seq_rep_pkg::*;
#(
  parameter int        NUM_CH  = 4,
  parameter int        REP_CNT = 3,
  parameter rep_mode_e MODE    = REP_NONCONSEC,
  parameter int        TIMEOUT = 64,
  parameter int        CNT_W   = 16
) (
  input logic                     clk,
  input logic                     rst,
  seq_repetition_checker_if.slave bus
);

  localparam int PW = cnt_bits(NUM_CH);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] busy_v;
  logic [NUM_CH-1:0] pass_v;
  logic [NUM_CH-1:0] fail_v;
  logic [NUM_CH-1:0] fail_to_v;
  logic [NUM_CH-1:0] dropped_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    seq_rep_channel #(
      .REP_CNT (REP_CNT),
      .MODE    (MODE),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .trig    (bus.trig[i]),
      .ev      (bus.ev[i]),
      .done    (bus.done[i]),
      .busy    (busy_v[i]),
      .pass    (pass_v[i]),
      .fail    (fail_v[i]),
      .fail_to (fail_to_v[i]),
      .dropped (dropped_v[i])
    );
  end

  logic [PW-1:0]    pass_pop, fail_pop;
  logic [SW-1:0]    pass_sum, fail_sum;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    pass_pop = '0;
    fail_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_pop = pass_pop + PW'(pass_v[i]);
      fail_pop = fail_pop + PW'(fail_v[i]);
    end
    // widened sum so a carry is seen and clamped
    pass_sum = SW'(pass_cnt_q) + SW'(pass_pop);
    fail_sum = SW'(fail_cnt_q) + SW'(fail_pop);
    pass_cnt_d = (pass_sum > SW'(CNT_MAX)) ?
                 CNT_MAX : pass_sum[CNT_W-1:0];
    fail_cnt_d = (fail_sum > SW'(CNT_MAX)) ?
                 CNT_MAX : fail_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.busy     = busy_v;
  assign bus.pass     = pass_v;
  assign bus.fail     = fail_v;
  assign bus.fail_to  = fail_to_v;
  assign bus.dropped  = dropped_v;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_seq_repetition_checker.sv
// Bench: four checkers (nonconsec, goto, consec, 2-bit counters)
// on shared stimulus, compared every cycle against a behavioural model.
module tb_seq_repetition_checker;
  import seq_rep_pkg::*;

  localparam int N  = 3;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] trig = '0, ev = '0, done = '0;

  seq_repetition_checker_if #(.NUM_CH(4), .CNT_W(16)) if_nc();
  seq_repetition_checker_if #(.NUM_CH(4), .CNT_W(16)) if_go();
  seq_repetition_checker_if #(.NUM_CH(4), .CNT_W(16)) if_cs();
  seq_repetition_checker_if #(.NUM_CH(4), .CNT_W(2))  if_sat();

  assign if_nc.en = en;    assign if_nc.trig = trig;
  assign if_nc.ev = ev;    assign if_nc.done = done;
  assign if_go.en = en;    assign if_go.trig = trig;
  assign if_go.ev = ev;    assign if_go.done = done;
  assign if_cs.en = en;    assign if_cs.trig = trig;
  assign if_cs.ev = ev;    assign if_cs.done = done;
  assign if_sat.en = en;   assign if_sat.trig = trig;
  assign if_sat.ev = ev;   assign if_sat.done = done;

  seq_repetition_checker #(.NUM_CH(4), .REP_CNT(N),
    .MODE(REP_NONCONSEC), .TIMEOUT(TO), .CNT_W(16))
    u_nc (.clk(clk), .rst(rst), .bus(if_nc));
  seq_repetition_checker #(.NUM_CH(4), .REP_CNT(N),
    .MODE(REP_GOTO), .TIMEOUT(TO), .CNT_W(16))
    u_go (.clk(clk), .rst(rst), .bus(if_go));
  seq_repetition_checker #(.NUM_CH(4), .REP_CNT(N),
    .MODE(REP_CONSEC), .TIMEOUT(TO), .CNT_W(16))
    u_cs (.clk(clk), .rst(rst), .bus(if_cs));
  seq_repetition_checker #(.NUM_CH(4), .REP_CNT(N),
    .MODE(REP_NONCONSEC), .TIMEOUT(TO), .CNT_W(2))
    u_sat (.clk(clk), .rst(rst), .bus(if_sat));

  logic [3:0]  o_busy[4], o_pass[4], o_fail[4], o_to[4], o_drop[4];
  logic [15:0] o_pc[4], o_fc[4];

  always_comb begin
    o_busy = '{if_nc.busy, if_go.busy, if_cs.busy, if_sat.busy};
    o_pass = '{if_nc.pass, if_go.pass, if_cs.pass, if_sat.pass};
    o_fail = '{if_nc.fail, if_go.fail, if_cs.fail, if_sat.fail};
    o_to   = '{if_nc.fail_to, if_go.fail_to,
               if_cs.fail_to, if_sat.fail_to};
    o_drop = '{if_nc.dropped, if_go.dropped,
               if_cs.dropped, if_sat.dropped};
    o_pc   = '{if_nc.pass_cnt, if_go.pass_cnt,
               if_cs.pass_cnt, 16'(if_sat.pass_cnt)};
    o_fc   = '{if_nc.fail_cnt, if_go.fail_cnt,
               if_cs.fail_cnt, 16'(if_sat.fail_cnt)};
  end

  // model: 0 nonconsec, 1 goto, 2 consec
  int md[4]   = '{0, 1, 2, 0};
  int cmax[4] = '{65535, 65535, 65535, 3};
  bit act[4][4];
  int k[4][4], el[4][4];
  bit [3:0] e_busy[4], e_pass[4], e_fail[4], e_to[4], e_drop[4];
  int e_pc[4], e_fc[4];

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input int m,
                     input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got %0h want %0h",
               nm, m, $time, a, e);
    end
  endtask

  task automatic model_step();
    bit p, f, t;
    for (int m = 0; m < 4; m++) begin
      if (rst) begin
        e_pc[m] = 0; e_fc[m] = 0;
        e_busy[m] = '0; e_pass[m] = '0; e_fail[m] = '0;
        e_to[m] = '0; e_drop[m] = '0;
        for (int c = 0; c < 4; c++) begin
          act[m][c] = 1'b0; k[m][c] = 0; el[m][c] = 0;
        end
      end else begin
        // totals lag the visible pulses by one cycle
        e_pc[m] = sat(e_pc[m] + $countones(e_pass[m]), cmax[m]);
        e_fc[m] = sat(e_fc[m] + $countones(e_fail[m]), cmax[m]);
        for (int c = 0; c < 4; c++) begin
          p = 0; f = 0; t = 0;
          e_drop[m][c] = trig[c] && act[m][c];
          if (en && act[m][c]) begin
            if (k[m][c] < N) begin
              if (ev[c]) k[m][c]++;
              else if (md[m] == 2) f = 1;
            end else if (done[c]) p = 1;
            else if (md[m] != 0 || ev[c]) f = 1;
            if (!p && !f) begin
              el[m][c]++;
              if (el[m][c] == TO) begin f = 1; t = 1; end
            end
            if (p || f) act[m][c] = 0;
          end else if (en && trig[c] && !act[m][c]) begin
            act[m][c] = 1; k[m][c] = int'(ev[c]); el[m][c] = 0;
          end
          e_pass[m][c] = p; e_fail[m][c] = f; e_to[m][c] = t;
          e_busy[m][c] = act[m][c];
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 4; m++) begin
        chk("busy", m, 32'(o_busy[m]), 32'(e_busy[m]));
        chk("pass", m, 32'(o_pass[m]), 32'(e_pass[m]));
        chk("fail", m, 32'(o_fail[m]), 32'(e_fail[m]));
        chk("fail_to", m, 32'(o_to[m]), 32'(e_to[m]));
        chk("dropped", m, 32'(o_drop[m]), 32'(e_drop[m]));
        chk("pass_cnt", m, 32'(o_pc[m]), e_pc[m]);
        chk("fail_cnt", m, 32'(o_fc[m]), e_fc[m]);
      end
    end
  end

  task automatic drive(input logic r, input logic e,
                       input logic [3:0] t, input logic [3:0] v,
                       input logic [3:0] d);
    @(negedge clk);
    #1;
    rst = r; en = e; trig = t; ev = v; done = d;
    model_step();
  endtask

  logic [3:0]  h_busy[4][80], h_pass[4][80], h_fail[4][80];
  logic [3:0]  h_to[4][80], h_drop[4][80];
  logic [15:0] h_pc[4][80];

  function automatic logic [79:0] bm(input int a, input int b = -1,
    input int c = -1, input int d = -1, input int e = -1);
    logic [79:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    if (e >= 0) r[e] = 1'b1;
    return r;
  endfunction

  // reset, then cycles 0..len-1 relative to the first trig
  task automatic scen(input logic [79:0] tm, input logic [79:0] em,
                      input logic [79:0] dm, input logic [79:0] rm,
                      input bit allch, input int len);
    logic [3:0] msk;
    msk = allch ? 4'hF : 4'h1;
    drive(1'b1, 1'b1, '0, '0, '0);
    for (int c = 0; c < len; c++) begin
      drive(rm[c], 1'b1, tm[c] ? msk : 4'h0,
            em[c] ? msk : 4'h0, dm[c] ? msk : 4'h0);
      for (int m = 0; m < 4; m++) begin
        h_busy[m][c] = o_busy[m]; h_pass[m][c] = o_pass[m];
        h_fail[m][c] = o_fail[m]; h_to[m][c] = o_to[m];
        h_drop[m][c] = o_drop[m]; h_pc[m][c] = o_pc[m];
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, '0, '0);
    chk_en = 1'b1;

    // nonconsec pass: ev 1,2,4 done 7
    scen(bm(0), bm(1, 2, 4), bm(7), '0, 0, 10);
    chk("rst_busy", 0, 32'(h_busy[0][0]), 0);
    chk("rst_pcnt", 0, 32'(h_pc[0][0]), 0);
    chk("nc_pass7", 0, 32'(h_pass[0][7][0]), 0);
    chk("nc_pass8", 0, 32'(h_pass[0][8][0]), 1);
    chk("nc_busy7", 0, 32'(h_busy[0][7][0]), 1);
    chk("nc_busy8", 0, 32'(h_busy[0][8][0]), 0);
    chk("nc_pcnt8", 0, 32'(h_pc[0][8]), 0);
    chk("nc_pcnt9", 0, 32'(h_pc[0][9]), 1);

    // nonconsec extra event
    scen(bm(0), bm(1, 2, 4, 5), '0, '0, 0, 8);
    chk("nc_xfail6", 0, 32'(h_fail[0][6][0]), 1);
    chk("nc_xto6", 0, 32'(h_to[0][6][0]), 0);
    chk("nc_xpass6", 0, 32'(h_pass[0][6][0]), 0);

    // nonconsec, ev in trigger cycle
    scen(bm(0), bm(0, 2, 4), bm(5), '0, 0, 8);
    chk("nc_ovl6", 0, 32'(h_pass[0][6][0]), 1);

    // goto
    scen(bm(0), bm(1, 3, 5), bm(6), '0, 0, 9);
    chk("go_pass7", 1, 32'(h_pass[1][7][0]), 1);
    scen(bm(0), bm(1, 3, 5), bm(7), '0, 0, 10);
    chk("go_fail7", 1, 32'(h_fail[1][7][0]), 1);
    chk("go_pass8", 1, 32'(h_pass[1][8][0]), 0);
    chk("nc_late8", 0, 32'(h_pass[0][8][0]), 1);

    // consec
    scen(bm(0), bm(0, 1, 2), bm(3), '0, 0, 6);
    chk("cs_pass4", 2, 32'(h_pass[2][4][0]), 1);
    scen(bm(0), bm(0, 2), '0, '0, 0, 5);
    chk("cs_fail1", 2, 32'(h_fail[2][1][0]), 0);
    chk("cs_fail2", 2, 32'(h_fail[2][2][0]), 1);

    // timeout with a dropped trig at 10
    scen(bm(0, 10), bm(1), '0, '0, 0, 68);
    chk("to_fail64", 0, 32'(h_fail[0][64][0]), 0);
    chk("to_fail65", 0, 32'(h_fail[0][65][0]), 1);
    chk("to_flag65", 0, 32'(h_to[0][65][0]), 1);
    chk("to_busy65", 0, 32'(h_busy[0][65][0]), 0);
    chk("drop10", 0, 32'(h_drop[0][10][0]), 0);
    chk("drop11", 0, 32'(h_drop[0][11][0]), 1);

    // five back-to-back passes, 2-bit counter saturates
    scen(bm(0, 4, 8, 12, 16), 80'hFFFFF, bm(3, 7, 11, 15, 19),
         '0, 0, 24);
    chk("sat13", 3, 32'(h_pc[3][13]), 3);
    chk("sat17", 3, 32'(h_pc[3][17]), 3);
    chk("sat23", 3, 32'(h_pc[3][23]), 3);
    chk("wide23", 0, 32'(h_pc[0][23]), 5);

    // all channels pass together
    scen(bm(0), bm(1, 2, 4), bm(7), '0, 1, 10);
    chk("mc_pass8", 0, 32'(h_pass[0][8]), 32'hF);
    chk("mc_pcnt9", 0, 32'(h_pc[0][9]), 4);

    // reset two cycles into a second attempt
    scen(bm(0, 6), bm(0, 1, 2, 7), bm(3), bm(8), 0, 12);
    chk("rs_pcnt5", 0, 32'(h_pc[0][5]), 1);
    chk("rs_busy8", 0, 32'(h_busy[0][8][0]), 1);
    chk("rs_busy9", 0, 32'(h_busy[0][9]), 0);
    chk("rs_pass9", 0, 32'(h_pass[0][9]), 0);
    chk("rs_fail9", 0, 32'(h_fail[0][9]), 0);
    chk("rs_pcnt9", 0, 32'(h_pc[0][9]), 0);

    // random traffic in three densities
    drive(1'b1, 1'b1, '0, '0, '0);
    for (int i = 0; i < 4500; i++) begin
      logic [3:0] t, v, d;
      t = 4'($urandom) & 4'($urandom);
      if (i < 1500) begin
        v = 4'($urandom);
        d = 4'($urandom) & 4'($urandom);
      end else if (i < 3000) begin
        v = 4'($urandom) | 4'($urandom);
        d = 4'($urandom) & 4'($urandom);
      end else begin
        v = '0; d = '0;
        for (int c = 0; c < 4; c++) begin
          v[c] = ($urandom_range(0, 39) == 0);
          d[c] = ($urandom_range(0, 39) == 0);
        end
      end
      drive($urandom_range(0, 499) == 0,
            $urandom_range(0, 9) != 0, t, v, d);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
